// File: rtl/cross_bar_slave_responder_pkg.sv
// Shared widths for the crossbar interface plus the responder's FSM state,
// command encoding and captured-request record.
package interface_connection;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

package cross_bar_slave_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ACK_DLY,
        ACK,
        PROC,
        RESP
    } fsm_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Captured index is stored wide enough for any practical MEM_DEPTH;
    // the top only uses the low IDX_W bits.
    localparam int CAP_IDX_W  = 16;
    localparam int CAP_DATA_W = interface_connection::DATA_WIDTH;

    typedef struct packed {
        logic [CAP_IDX_W-1:0]  idx;
        logic                  cmd;
        logic [CAP_DATA_W-1:0] wdata;
    } req_cap_t;
endpackage

// File: rtl/cross_bar_slave_responder_mem.sv
// Word-addressed register memory: synchronous write, combinational read,
// contents are never reset.
module slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/cross_bar_slave_responder.sv
// Crossbar slave-end responder: captures one request, acknowledges it after
// ACK_DELAY cycles, performs the memory access, and answers with resp/rdata
// RESP_LATENCY cycles later. All outputs are registered.
module cross_bar_slave_responder
    import cross_bar_slave_pkg::*;
#(
    parameter int ADDR_WIDTH   = interface_connection::ADDR_WIDTH,
    parameter int DATA_WIDTH   = interface_connection::DATA_WIDTH,
    parameter int MEM_DEPTH    = 16,
    parameter int ACK_DELAY    = 0,
    parameter int RESP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);
    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0] ACK_CNT  = 4'(ACK_DELAY);
    localparam logic [3:0] RESP_CNT = 4'(RESP_LATENCY);

    fsm_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    req_cap_t              cap_q;
    logic                  capture;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  ack_d, resp_d, busy_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  unused_bits;

    // Upper address bits are ignored: the index wraps modulo MEM_DEPTH.
    assign mem_idx     = cap_q.idx[IDX_W-1:0];
    assign unused_bits = ^{addr[ADDR_WIDTH-1:IDX_W], cap_q.idx[CAP_IDX_W-1:IDX_W]};

    slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (DATA_WIDTH'(cap_q.wdata)),
        .rdata (mem_rdata)
    );

    // Next-state, counter and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        capture = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = ACK_CNT;
                    state_d = (ACK_DELAY > 0) ? ACK_DLY : ACK;
                end
            end
            ACK_DLY: begin
                if (cnt_q <= 4'd1) state_d = ACK;
            end
            ACK: begin
                // A write landing on a reset edge must not disturb memory.
                mem_we  = (cap_q.cmd == CMD_WRITE) && rst_n;
                cnt_d   = RESP_CNT;
                state_d = (RESP_LATENCY > 0) ? PROC : RESP;
            end
            PROC: begin
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d   = (state_d == ACK);
        resp_d  = (state_d == RESP);
        busy_d  = (state_d != IDLE);
        rdata_d = '0;
        // With zero response latency the read goes straight from memory to rdata.
        if (state_d == RESP && cap_q.cmd == CMD_READ) begin
            rdata_d = (state_q == ACK) ? mem_rdata : rd_q;
        end
    end

    // Control state and outputs, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack     <= 1'b0;
            resp    <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack     <= ack_d;
            resp    <= resp_d;
            busy    <= busy_d;
            rdata   <= rdata_d;
        end
    end

    // Captured request and read-data hold register (data only, no reset).
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_q.idx   <= CAP_IDX_W'(addr[IDX_W-1:0]);
            cap_q.cmd   <= cmd;
            cap_q.wdata <= CAP_DATA_W'(wdata);
        end
        if (state_q == ACK && cap_q.cmd == CMD_READ) begin
            rd_q <= mem_rdata;
        end
    end
endmodule
